// File: rtl/sakebi_eth_rx_frame.sv
// sakebi_eth_rx_frame
// Ethernet receive frame checker. Consumes post-SFD bytes (frame end on
// TLAST), runs CRC-32 over every byte including the FCS, checks the frame
// length, strips the 4 FCS bytes through a 4-deep delay line and forwards
// DA..last data byte on an AXI-Stream master. TUSER on the last beat flags
// a bad frame.
//
// Ports
//   i_axis_ACLK / i_axis_ARESETn : clock, async active-low reset
//   i_s_axis_*  / o_s_axis_TREADY : byte stream in (TLAST = final FCS byte)
//   o_m_axis_*  / i_m_axis_TREADY : payload stream out, TUSER = frame bad
//   o_frame_ok / o_frame_err      : one-cycle pulse after each frame end
//   o_good_cnt / o_bad_cnt        : saturating frame counters
module sakebi_eth_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
) (
  input  logic                  i_axis_ACLK,
  input  logic                  i_axis_ARESETn,
  input  logic                  i_s_axis_TVALID,
  output logic                  o_s_axis_TREADY,
  input  logic [DATA_WIDTH-1:0] i_s_axis_TDATA,
  input  logic                  i_s_axis_TLAST,
  output logic                  o_m_axis_TVALID,
  input  logic                  i_m_axis_TREADY,
  output logic [DATA_WIDTH-1:0] o_m_axis_TDATA,
  output logic                  o_m_axis_TLAST,
  output logic                  o_m_axis_TUSER,
  output logic                  o_frame_ok,
  output logic                  o_frame_err,
  output logic [15:0]           o_good_cnt,
  output logic [15:0]           o_bad_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  // Running the reflected CRC over data+FCS without the final inversion
  // always leaves this constant when the FCS is correct.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] LEN_SAT     = 11'h7FF;
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
  localparam logic [15:0] CNT_SAT     = 16'hFFFF;

  function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                           input logic [DATA_WIDTH-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < DATA_WIDTH; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  state_t                     state, state_nxt;
  logic [2:0]                 cnt;
  logic [3:0][DATA_WIDTH-1:0] line;
  logic [31:0]                crc;
  logic [10:0]                len;

  logic                       accept, pop, fin;
  logic [31:0]                crc_nxt;
  logic [10:0]                len_nxt;
  logic                       bad_chk, bad_frame;

  logic                       m_valid, m_last, m_user;
  logic [DATA_WIDTH-1:0]      m_data;
  logic                       ok_q, err_q;
  logic [15:0]                good_q, bad_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (i_s_axis_TLAST)                     state_nxt = IDLE;
      else if (state == STREAM || cnt == 3'd3) state_nxt = STREAM;
      else                                     state_nxt = FILL;
    end
  end

  // Input ready never looks at TVALID: only a full line with a stalled
  // output register can block the input.
  always_comb begin
    o_s_axis_TREADY = (state != STREAM) || !m_valid || i_m_axis_TREADY;
    accept          = i_s_axis_TVALID && o_s_axis_TREADY;
    pop             = accept && (state == STREAM);
    fin             = accept && i_s_axis_TLAST;
    crc_nxt         = crc_byte(crc, i_s_axis_TDATA);
    len_nxt         = (len == LEN_SAT) ? len : len + 11'd1;
    bad_chk         = (crc_nxt != CRC_RESIDUE) || (len_nxt < MIN_L) ||
                      (len_nxt > MAX_L);
    // A frame of four bytes or fewer never popped anything: always bad.
    bad_frame       = bad_chk || !pop;
  end

  // ------------------------------------------------------ delay line
  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      cnt  <= '0;
      line <= '0;
      crc  <= CRC_INIT;
      len  <= '0;
    end else if (accept) begin
      if (pop) line <= {i_s_axis_TDATA, line[3], line[2], line[1]};
      else     line[cnt[1:0]] <= i_s_axis_TDATA;
      if (i_s_axis_TLAST) begin
        cnt <= '0;
        crc <= CRC_INIT;
        len <= '0;
      end else begin
        if (!pop) cnt <= cnt + 3'd1;
        crc <= crc_nxt;
        len <= len_nxt;
      end
    end
  end

  // ------------------------------------------------- output register
  // Pop only happens when the register is empty or being drained, so a
  // reload on the accepting cycle gives back-to-back beats with no bubble.
  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_user  <= 1'b0;
    end else if (pop) begin
      m_valid <= 1'b1;
      m_data  <= line[0];
      m_last  <= i_s_axis_TLAST;
      m_user  <= i_s_axis_TLAST && bad_chk;
    end else if (i_m_axis_TREADY) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_user  <= 1'b0;
    end
  end

  // --------------------------------------------- status and counters
  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      ok_q  <= fin && !bad_frame;
      err_q <= fin && bad_frame;
      if (fin && !bad_frame && good_q != CNT_SAT) good_q <= good_q + 16'd1;
      if (fin &&  bad_frame && bad_q  != CNT_SAT) bad_q  <= bad_q  + 16'd1;
    end
  end

  assign o_m_axis_TVALID = m_valid;
  assign o_m_axis_TDATA  = m_data;
  assign o_m_axis_TLAST  = m_last;
  assign o_m_axis_TUSER  = m_user;
  assign o_frame_ok      = ok_q;
  assign o_frame_err     = err_q;
  assign o_good_cnt      = good_q;
  assign o_bad_cnt       = bad_q;

endmodule

// File: tb/tb_sakebi_eth_rx_frame.sv
module tb_sakebi_eth_rx_frame;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        m_valid, m_ready, m_last, m_user;
  logic [7:0]  m_data;
  logic        frame_ok, frame_err;
  logic [15:0] good_cnt, bad_cnt;

  sakebi_eth_rx_frame #(.DATA_WIDTH(8), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .i_axis_ACLK     (clk),
    .i_axis_ARESETn  (rst_n),
    .i_s_axis_TVALID (s_valid),
    .o_s_axis_TREADY (s_ready),
    .i_s_axis_TDATA  (s_data),
    .i_s_axis_TLAST  (s_last),
    .o_m_axis_TVALID (m_valid),
    .i_m_axis_TREADY (m_ready),
    .o_m_axis_TDATA  (m_data),
    .o_m_axis_TLAST  (m_last),
    .o_m_axis_TUSER  (m_user),
    .o_frame_ok      (frame_ok),
    .o_frame_err     (frame_err),
    .o_good_cnt      (good_cnt),
    .o_bad_cnt       (bad_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // reference model state
  logic [7:0] in_d[$];
  logic       in_l[$];
  beat_t      exp_q[$];
  int         exp_ok = 0, exp_err = 0;
  int         good_m = 0, bad_m = 0;
  int         fcnt = 0;   // bytes of the current frame held back (max 4)

  // Standard Ethernet CRC-32 (inverted result), as carried in the FCS.
  function automatic logic [31:0] crc32(input byte_q_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic byte_q_t make_frame(input int plen, input bit rnd);
    byte_q_t     f;
    logic [31:0] c;
    for (int i = 0; i < plen; i++) f.push_back(rnd ? 8'($urandom) : 8'(i));
    c = crc32(f, plen);
    for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
    return f;
  endfunction

  // Queue one frame for the input and derive the expected output from
  // length and FCS-vs-payload comparison.
  task automatic add_frame(input byte_q_t fr);
    int          n;
    bit          bad;
    logic [31:0] c;
    beat_t       b;
    n   = fr.size();
    bad = (n <= 4) || (n < MIN_LEN) || (n > MAX_LEN);
    if (n > 4) begin
      c = crc32(fr, n - 4);
      if ({fr[n-1], fr[n-2], fr[n-3], fr[n-4]} != c) bad = 1;
    end
    for (int i = 0; i < n; i++) begin
      in_d.push_back(fr[i]);
      in_l.push_back(i == n - 1);
    end
    for (int i = 0; i < n - 4; i++) begin
      b.d = fr[i];
      b.l = (i == n - 5);
      b.u = bad;
      exp_q.push_back(b);
    end
    if (bad) begin exp_err++; bad_m++; end
    else     begin exp_ok++;  good_m++; end
  endtask

  // Drive all queued bytes back-to-back. mode: 0 ready=1, 1 toggle, 2 random.
  task automatic run(input int mode);
    int         idx = 0, cyc = 0, drain = 0, ok_seen = 0, err_seen = 0;
    int         n, bound;
    bit         stall_prev = 0;
    logic [9:0] prev = '0;
    beat_t      e;
    logic       exp_rdy;
    n     = in_d.size();
    bound = 20 * n + 100;
    while ((idx < n || exp_q.size() > 0 || drain < 3) && cyc < bound) begin
      @(negedge clk);
      m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !m_ready : 1'($urandom_range(0, 1));
      s_valid = (idx < n);
      s_data  = (idx < n) ? in_d[idx] : 8'h00;
      s_last  = (idx < n) ? in_l[idx] : 1'b0;
      #1;
      exp_rdy = (fcnt < 4) || !m_valid || m_ready;
      checks++;
      if (s_ready !== exp_rdy) $display("FAIL in_ready got %b exp %b", s_ready, exp_rdy);
      else passed++;
      if (stall_prev) begin
        checks++;
        if ({m_data, m_last, m_user} !== prev)
          $display("FAIL hold_stable got %h exp %h", {m_data, m_last, m_user}, prev);
        else passed++;
      end
      if (frame_ok)  ok_seen++;
      if (frame_err) err_seen++;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL extra_beat got %h exp none", m_data);
        else begin
          e = exp_q.pop_front();
          if (m_data !== e.d || m_last !== e.l || (e.l && m_user !== e.u))
            $display("FAIL beat got d=%h l=%b u=%b exp d=%h l=%b u=%b",
                     m_data, m_last, m_user, e.d, e.l, e.u);
          else passed++;
        end
      end
      if (s_valid && s_ready) begin
        fcnt = s_last ? 0 : ((fcnt < 4) ? fcnt + 1 : 4);
        idx++;
      end
      stall_prev = m_valid && !m_ready;
      prev       = {m_data, m_last, m_user};
      if (idx == n && exp_q.size() == 0) drain++;
      cyc++;
    end
    @(negedge clk);
    s_valid = 0; s_last = 0; m_ready = 1;
    checks++;
    if (cyc >= bound) $display("FAIL timeout got %0d cycles exp <%0d", cyc, bound);
    else passed++;
    checks++;
    if (ok_seen != exp_ok) $display("FAIL ok_pulses got %0d exp %0d", ok_seen, exp_ok);
    else passed++;
    checks++;
    if (err_seen != exp_err) $display("FAIL err_pulses got %0d exp %0d", err_seen, exp_err);
    else passed++;
    checks++;
    if (good_cnt !== 16'(good_m)) $display("FAIL good_cnt got %0d exp %0d", good_cnt, good_m);
    else passed++;
    checks++;
    if (bad_cnt !== 16'(bad_m)) $display("FAIL bad_cnt got %0d exp %0d", bad_cnt, bad_m);
    else passed++;
    in_d.delete(); in_l.delete(); exp_q.delete();
    exp_ok = 0; exp_err = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; s_valid = 0; s_data = 0; s_last = 0; m_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) $display("FAIL rst_tvalid got %b exp 0", m_valid); else passed++;
    checks++; if (m_data !== 8'h00) $display("FAIL rst_tdata got %h exp 00", m_data); else passed++;
    checks++; if (m_last !== 1'b0) $display("FAIL rst_tlast got %b exp 0", m_last); else passed++;
    checks++; if (m_user !== 1'b0) $display("FAIL rst_tuser got %b exp 0", m_user); else passed++;
    checks++; if (frame_ok !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL rst_pulses got %b%b exp 00", frame_ok, frame_err); else passed++;
    checks++; if (good_cnt !== 16'h0 || bad_cnt !== 16'h0)
      $display("FAIL rst_counters got %0d/%0d exp 0/0", good_cnt, bad_cnt); else passed++;
    checks++; if (s_ready !== 1'b1) $display("FAIL rst_tready got %b exp 1", s_ready); else passed++;
    @(negedge clk);
    rst_n = 1;
    fcnt = 0; good_m = 0; bad_m = 0;
  endtask

  task automatic test_good_frame;
    add_frame(make_frame(60, 0));
    run(0);
  endtask

  task automatic test_bad_crc;
    byte_q_t f;
    f = make_frame(60, 0);
    f[10] = f[10] ^ 8'h01;
    add_frame(f);
    run(0);
  endtask

  task automatic test_length;
    add_frame(make_frame(36, 0));     // runt, good FCS
    run(0);
    add_frame(make_frame(1515, 0));   // giant, good FCS
    run(0);
    add_frame(make_frame(1514, 1));   // largest legal frame
    run(0);
  endtask

  task automatic test_tiny;
    byte_q_t f;
    f = '{8'hAA, 8'h55, 8'hC3};
    add_frame(f);
    add_frame(make_frame(60, 0));
    run(0);
  endtask

  task automatic test_backpressure;
    add_frame(make_frame(60, 0));
    run(1);
    add_frame(make_frame(70, 1));
    run(2);
  endtask

  task automatic test_back_to_back;
    byte_q_t f;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          f.delete();
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) f.push_back(8'($urandom));
        end
        1: f = make_frame($urandom_range(60, 100), 1);
        2: begin
          f = make_frame($urandom_range(30, 90), 1);
          f[$urandom_range(0, 20)] ^= 8'(1 << $urandom_range(0, 7));
        end
        default: f = make_frame($urandom_range(20, 59), 1);
      endcase
      add_frame(f);
    end
    run(2);
  endtask

  task automatic test_reset_midframe;
    byte_q_t f;
    int      sent = 0, cyc = 0;
    f = make_frame(60, 1);
    while (sent < 20 && cyc < 200) begin
      @(negedge clk);
      m_ready = 1; s_valid = 1; s_data = f[sent]; s_last = 0;
      #1;
      if (s_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    rst_n = 0; s_valid = 0;
    #1;
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL midrst_clear got v=%b r=%b exp v=0 r=1", m_valid, s_ready); else passed++;
    checks++; if (good_cnt !== 16'h0 || bad_cnt !== 16'h0)
      $display("FAIL midrst_counters got %0d/%0d exp 0/0", good_cnt, bad_cnt); else passed++;
    @(negedge clk);
    rst_n = 1;
    fcnt = 0; good_m = 0; bad_m = 0;
    add_frame(make_frame(60, 0));
    run(0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_length();
    test_tiny();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sakebi_eth_rx_frame.md
# sakebi_eth_rx_frame

Ethernet receive frame checker that sits directly downstream of the RMII receive stage. It consumes the byte stream that stage produces (post-SFD bytes, frame end marked by TLAST) and computes and checks the CRC-32 FCS. It strips the 4 FCS bytes, checks frame length, and forwards payload bytes (DA through last data byte) on an AXI-Stream master. A per-frame error flag rides on the last byte.

## Interface
Parameters:
- DATA_WIDTH, 8, stream byte width; only 8 is supported.
- MIN_LEN, 64, minimum legal frame length in bytes, FCS included.
- MAX_LEN, 1518, maximum legal frame length in bytes, FCS included.

Ports:
- i_axis_ACLK  in  1  single clock for all logic.
- i_axis_ARESETn  in  1  asynchronous active-low reset.
- i_s_axis_TVALID  in  1  input byte valid.
- o_s_axis_TREADY  out  1  input byte accepted when TVALID && TREADY.
- i_s_axis_TDATA  in  DATA_WIDTH  input byte, wire order.
- i_s_axis_TLAST  in  1  last byte of frame (final FCS byte).
- o_m_axis_TVALID  out  1  output byte valid.
- i_m_axis_TREADY  in  1  downstream ready.
- o_m_axis_TDATA  out  DATA_WIDTH  payload byte.
- o_m_axis_TLAST  out  1  last payload byte of frame.
- o_m_axis_TUSER  out  1  frame bad; meaningful only with TLAST.
- o_frame_ok  out  1  one-cycle pulse per good frame.
- o_frame_err  out  1  one-cycle pulse per bad or empty frame.
- o_good_cnt  out  16  saturating good-frame count.
- o_bad_cnt  out  16  saturating bad-frame count.

## Operation
- Delay line: 4-entry byte FIFO line[0..3] with occupancy cnt (0..4). A byte leaves the line only when a newer byte is pushed with cnt==4, so the final 4 bytes of every frame (the FCS) are never emitted.
- States:
  - IDLE: cnt=0, CRC=0xFFFFFFFF, len=0.
  - FILL: cnt<4.
  - STREAM: cnt==4.
  - Accepting a byte without TLAST: IDLE->FILL->...->STREAM.
  - Accepting a byte with TLAST: ->IDLE in all cases.
- Output register: {TDATA, TLAST, TUSER, TVALID}. It holds until i_m_axis_TREADY.
- o_s_axis_TREADY = (cnt<4) || !o_m_axis_TVALID || i_m_axis_TREADY. It is combinational and contains no dependency on i_s_axis_TVALID.
- On each accepted byte:
  - CRC update: reflected poly 0xEDB88320, LSB first, over every byte including the FCS.
  - len = len+1, saturating at 2047 (11 bits).
  - If cnt==4: pop line[0] into the output register (TVALID=1) and push the new byte.
  - Otherwise: push the new byte and increment cnt.
- On an accepted byte with TLAST (using the post-update CRC and len):
  - bad = (crc != 0xDEBB20E3) || (len < MIN_LEN) || (len > MAX_LEN).
  - If a byte was popped this cycle, it carries TLAST=1 and TUSER=bad.
  - If no byte was popped (frame ≤4 bytes): emit nothing and treat the frame as bad.
  - o_frame_ok or o_frame_err pulses on the next cycle.
  - The matching counter increments, saturating at 0xFFFF.
  - Line cleared (cnt=0), CRC and len re-initialised.
- Back-to-back frames: the first byte of the next frame is accepted the cycle after TLAST. It is hashed from init.
- No partial-frame timeout. A frame ends only on TLAST.

## Timing
- Reset values: o_m_axis_TVALID, TLAST, TUSER = 0; TDATA = 0; o_frame_ok, o_frame_err = 0; counters = 0; o_s_axis_TREADY = 1 (cnt=0). Internal state is IDLE.
- Latency: payload byte k appears on o_m_axis_* the cycle after input byte k+4 is accepted.
- Throughput: 1 byte/cycle sustained when downstream is always ready.
- Backpressure:
  - While the output is stalled and cnt==4, TREADY=0 and the input is held.
  - TDATA, TLAST, TUSER are stable while TVALID && !TREADY.
- Simultaneous output-accept and new pop: the register reloads in the same cycle with no bubble.
- Reset mid-frame: asynchronous clear to the reset values above. The partial frame is discarded and no pulse is produced. The next accepted byte starts a new frame.

## Test plan
- 64-byte frame (60 payload bytes 0x00..0x3B + correct FCS), TREADY=1: 60 bytes out in order, TLAST on byte 0x3B, TUSER=0, one o_frame_ok pulse, o_good_cnt=1.
- Same frame with bit 0 of payload byte 10 flipped: 60 bytes out, TUSER=1 on last, one o_frame_err pulse, o_bad_cnt=1.
- 40-byte frame with correct FCS (runt): 36 bytes out, TUSER=1. 1519-byte frame with correct FCS (giant): TUSER=1.
- 3-byte frame with TLAST on byte 3: no output beat, one o_frame_err pulse, o_bad_cnt=1. The next valid 64-byte frame passes with TUSER=0.
- Valid 64-byte frame with i_m_axis_TREADY toggling 1/0 each cycle and TVALID always high on input: output data identical to the no-stall case, no byte lost or duplicated, TREADY drops only when cnt==4 and output stalled.
- Assert i_axis_ARESETn low after 20 bytes of a frame, release, send a valid 64-byte frame: only 60 bytes of the second frame out, TUSER=0, o_good_cnt=1, o_bad_cnt=0.
